fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32 core. It holds the PC, issues word requests to instruction memory, and buffers the returned instruction plus its PC.
- It presents them to decode, where the instruction word feeds the immediate generator and the opcode/field decoder.
- At most one memory request is outstanding at a time. A 2-entry output buffer (output register plus skid register) absorbs decode back-pressure.
- Branch/jump redirects from execute flush the buffer and any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000: PC fetched first after reset. Bits [1:0] must be 0.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; arrives at least 1 cycle after acceptance; exactly one response per accepted request.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and forced to 0.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode consumes this cycle.
- id_instr  out  32  instruction to decode/ImmGen.
- id_pc  out  32  PC of id_instr.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc_q=RESET_PC, state=REQ.
  - Output buffer and skid register empty.
  - id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0.
  - imem_req_valid=0 while rst_n=0.
  - Reset mid-transaction abandons everything; memory must not return a response after reset.
- States:
  - REQ:
    - imem_req_valid=1 only when the skid register is empty; imem_req_addr=pc_q.
    - On handshake: req_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), go to WAIT.
  - WAIT:
    - imem_req_valid=0.
    - On imem_rsp_valid: write {data, req_pc} to the output register if it is empty or draining this cycle (id_valid&id_ready); otherwise write it to the skid register. Go to REQ.
  - DROP:
    - imem_req_valid=0.
    - On imem_rsp_valid: discard the data, go to REQ.
- Buffer:
  - When the output register drains while the skid register is full, the skid entry moves to the output register in the same edge.
  - id_valid=1 whenever the output register is full.
  - id_instr and id_pc stay stable while id_valid=1 and id_ready=0.
  - An empty output register drives the NOP and id_pc unchanged.
- Redirect (highest priority, any state):
  - pc_q<={redirect_pc[31:2],2'b00}.
  - Output and skid registers cleared; id_valid=0 the next cycle. A decode handshake in the same cycle is still counted as a consume.
  - REQ without handshake: stay in REQ.
  - REQ with handshake in the same cycle: go to DROP.
  - WAIT without rsp_valid: go to DROP.
  - WAIT with rsp_valid in the same cycle: discard the response, go to REQ.
  - DROP without rsp_valid: stay in DROP.
  - DROP with rsp_valid: go to REQ.
- Latency: with a zero-wait memory (ready=1, rsp 1 cycle after accept), the first id_valid=1 occurs in the 3rd cycle after rst_n rises. Steady-state throughput is 1 instruction per 2 cycles.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Extra output port perf_fetched (32 bits), reset to 0.
  - Increments by 1 on each id_valid&id_ready handshake and wraps at 2^32.
  - Not cleared by redirect.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, DROP}.
  - NOP_INSTR = 32'h0000_0013.
  - PC_STEP = 32'd4.
  - typedef fetch_entry_t struct {instr[31:0], pc[31:0]}.
- Sub-module fetch_buf holds the 2-entry output/skid buffer. Interface:
  - push, push_entry, full_skid
  - pop (id_ready), flush
  - out_valid, out_entry
- fetch_stage keeps the PC, FSM and redirect logic.

Test Plan:
- Zero-wait memory returning addr-encoded data, id_ready=1, RESET_PC=0x100 -> requests to 0x100, 0x104, 0x108; id_pc/id_instr match in order; first id_valid 3 cycles after reset release.
- id_ready=0 for 6 cycles -> output and skid fill; imem_req_valid held 0 while skid is full; id_instr stable. Release -> 0x100, 0x104, 0x108 delivered with no loss or duplication.
- redirect_valid with redirect_pc=0x2003 while in WAIT, response arriving 3 cycles later -> stale response dropped; next request addr=0x2000; first id_pc=0x2000.
- Redirect in the same cycle as imem_rsp_valid, and separately in the same cycle as a REQ handshake -> no stale instruction reaches decode in either case.
- pc_q=0xFFFF_FFFC fetch -> next request address 0x0000_0000.
- rst_n low for 1 cycle while in WAIT with a full buffer -> id_valid=0, id_instr=0x13, next request at RESET_PC. With FETCH_PERF_CNT_EN, perf_fetched=0 after reset and =N after N handshakes.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
// Optional perf counter in fetch_stage is enabled with FETCH_PERF_CNT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch output buffer: an output register facing decode plus a
// skid register that catches a response arriving while decode is stalled.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         out_valid,
    output fetch_entry_t out_entry,
    output logic         full_skid
);

    logic         out_valid_reg;
    logic         skid_valid_reg;
    fetch_entry_t out_entry_reg;
    fetch_entry_t skid_entry_reg;
    logic         out_free;

    // The output slot can take new data when empty or being consumed this edge.
    assign out_free = !out_valid_reg || pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            out_entry_reg  <= '{instr: NOP_INSTR, pc: 32'h0000_0000};
            skid_entry_reg <= '{instr: NOP_INSTR, pc: 32'h0000_0000};
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                out_entry_reg  <= skid_entry_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= push;
                if (push) begin
                    skid_entry_reg <= push_entry;
                end
            end else begin
                out_valid_reg <= push;
                if (push) begin
                    out_entry_reg <= push_entry;
                end
            end
        end else if (push) begin
            skid_valid_reg <= 1'b1;
            skid_entry_reg <= push_entry;
        end
    end

    // An empty slot presents a NOP but keeps the last PC visible.
    assign out_valid = out_valid_reg;
    assign out_entry = '{instr: (out_valid_reg ? out_entry_reg.instr : NOP_INSTR),
                         pc:    out_entry_reg.pc};
    assign full_skid = skid_valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC, single-outstanding request FSM, redirect
// handling. Define FETCH_PERF_CNT_EN to add the perf_fetched counter port.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched
`endif
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  req_pc_reg, req_pc_next;
    logic         req_fire;
    logic         push;
    logic         full_skid;
    logic         out_valid;
    fetch_entry_t push_entry;
    fetch_entry_t out_entry;

    // Holding off requests while the skid is full guarantees every response has a slot.
    assign imem_req_valid = rst_n && (state_reg == REQ) && !full_skid;
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = (state_reg == WAIT) && imem_rsp_valid && !redirect_valid;
    assign push_entry     = '{instr: imem_rsp_data, pc: req_pc_reg};

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        if (req_fire) begin
            req_pc_next = pc_reg;
            pc_next     = pc_reg + PC_STEP;
        end
        case (state_reg)
            REQ:     if (req_fire) state_next = redirect_valid ? DROP : WAIT;
            WAIT:    if (imem_rsp_valid) state_next = REQ;
                     else if (redirect_valid) state_next = DROP;
            DROP:    if (imem_rsp_valid) state_next = REQ;
            default: state_next = REQ;
        endcase
        // A request accepted alongside a redirect is stale; DROP swallows its response.
        if (redirect_valid) begin
            pc_next = align_pc(redirect_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= REQ;
            pc_reg     <= RESET_PC;
            req_pc_reg <= RESET_PC;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            req_pc_reg <= req_pc_next;
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (id_ready),
        .flush      (redirect_valid),
        .out_valid  (out_valid),
        .out_entry  (out_entry),
        .full_skid  (full_skid)
    );

    assign id_valid = out_valid;
    assign id_instr = out_entry.instr;
    assign id_pc    = out_entry.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_reg;

    // Counts decode handshakes, including one coinciding with a redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_reg <= 32'h0000_0000;
        end else if (id_valid && id_ready) begin
            perf_fetched_reg <= perf_fetched_reg + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage with a behavioural single-outstanding
// instruction memory returning address-encoded data (addr | 0xC000_0000).
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
`endif

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;
        int          lat;
        bit          ereq;
        logic [31:0] eaddr;
        bit          eidv;
        logic [31:0] einstr;
        logic [31:0] epc;
    } vec_t;

    vec_t        vq[$];
    int          n_chk;
    int          n_err;
    logic [31:0] exp_perf;
    bit          pend;
    logic [31:0] pend_addr;
    int          wcnt;

    function automatic vec_t mk(bit rst, bit rdy, bit redir, logic [31:0] rpc, int lat,
                                bit ereq, logic [31:0] eaddr,
                                bit eidv, logic [31:0] einstr, logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.lat = lat;
        v.ereq = ereq; v.eaddr = eaddr; v.eidv = eidv; v.einstr = einstr; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Enter at a falling edge; leaves rst_n released at a falling edge.
    task automatic do_reset(input int cycles);
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        #1;
        chk("req_valid_in_reset", {31'h0, imem_req_valid}, 32'h0);
        repeat (cycles) @(posedge clk);
        pend     = 1'b0;
        wcnt     = 0;
        exp_perf = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs, then advance the memory model.
    task automatic apply(input vec_t v, input int idx);
        bit          acc;
        bit          rsp;
        logic [31:0] acc_addr;
        if (v.rst) do_reset(2);
        id_ready       = v.rdy;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        imem_rsp_valid = pend && (wcnt == 0);
        imem_rsp_data  = (pend && (wcnt == 0)) ? (pend_addr | 32'hC000_0000) : 32'h0;
        #1;
        $display("vec %0d: req=%0b addr=%h id_valid=%0b instr=%h pc=%h",
                 idx, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc);
        chk($sformatf("v%0d req_valid", idx), {31'h0, imem_req_valid}, {31'h0, v.ereq});
        if (v.ereq) chk($sformatf("v%0d req_addr", idx), imem_req_addr, v.eaddr);
        chk($sformatf("v%0d id_valid", idx), {31'h0, id_valid}, {31'h0, v.eidv});
        chk($sformatf("v%0d id_instr", idx), id_instr, v.einstr);
        chk($sformatf("v%0d id_pc", idx), id_pc, v.epc);
`ifdef FETCH_PERF_CNT_EN
        chk($sformatf("v%0d perf_fetched", idx), perf_fetched, exp_perf);
`endif
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rsp      = imem_rsp_valid;
        chk($sformatf("v%0d single_outstanding", idx), {31'h0, (acc && pend && !rsp)}, 32'h0);
        if (id_valid && id_ready) exp_perf = exp_perf + 32'd1;
        @(posedge clk);
        if (rsp) pend = 1'b0;
        else if (pend && wcnt > 0) wcnt--;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = acc_addr;
            wcnt      = v.lat - 1;
        end
        @(negedge clk);
    endtask

    initial begin
        n_chk          = 0;
        n_err          = 0;
        exp_perf       = 32'h0;
        pend           = 1'b0;
        pend_addr      = 32'h0;
        wcnt           = 0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;

        // Zero-wait streaming, decode always ready
        vq.push_back(mk(1, 1, 0, 0, 1, 1, 32'h100, 0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,   0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0, 1, 1, 32'h104, 1, 32'hC000_0100, 32'h100));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,   0, NOP, 32'h100));
        vq.push_back(mk(0, 1, 0, 0, 1, 1, 32'h108, 1, 32'hC000_0104, 32'h104));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,   0, NOP, 32'h104));
        vq.push_back(mk(0, 1, 0, 0, 1, 1, 32'h10C, 1, 32'hC000_0108, 32'h108));
        // Decode stalled six cycles: output and skid fill, requests pause
        vq.push_back(mk(1, 0, 0, 0, 1, 1, 32'h100, 0, NOP, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,   0, NOP, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 1, 1, 32'h104, 1, 32'hC000_0100, 32'h100));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,   1, 32'hC000_0100, 32'h100));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,   1, 32'hC000_0100, 32'h100));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,   1, 32'hC000_0100, 32'h100));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,   1, 32'hC000_0100, 32'h100));
        vq.push_back(mk(0, 1, 0, 0, 1, 1, 32'h108, 1, 32'hC000_0104, 32'h104));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,   0, NOP, 32'h104));
        vq.push_back(mk(0, 1, 0, 0, 1, 1, 32'h10C, 1, 32'hC000_0108, 32'h108));
        // Redirect in WAIT, stale response three cycles later
        vq.push_back(mk(1, 1, 0, 0,          4, 1, 32'h100,  0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 1, 32'h2003,   1, 0, 32'h0,    0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,          1, 0, 32'h0,    0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,          1, 0, 32'h0,    0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,          1, 0, 32'h0,    0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,          1, 1, 32'h2000, 0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,          1, 0, 32'h0,    0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,          1, 1, 32'h2004, 1, 32'hC000_2000, 32'h2000));
        // Redirect coinciding with the response
        vq.push_back(mk(1, 1, 0, 0,        1, 1, 32'h100,  0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 1, 32'h3000, 1, 0, 32'h0,    0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,        1, 1, 32'h3000, 0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,        1, 0, 32'h0,    0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,        1, 1, 32'h3004, 1, 32'hC000_3000, 32'h3000));
        // Redirect coinciding with the request handshake
        vq.push_back(mk(1, 1, 1, 32'h4000, 1, 1, 32'h100,  0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,        1, 0, 32'h0,    0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,        1, 1, 32'h4000, 0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,        1, 0, 32'h0,    0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,        1, 1, 32'h4004, 1, 32'hC000_4000, 32'h4000));
        // Unaligned redirect to the top word, then PC wraps to zero
        vq.push_back(mk(1, 1, 1, 32'hFFFF_FFFF, 1, 1, 32'h100,       0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,             1, 0, 32'h0,         0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,             1, 1, 32'hFFFF_FFFC, 0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,             1, 0, 32'h0,         0, NOP, 32'h0));
        vq.push_back(mk(0, 1, 0, 0,             1, 1, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        vq.push_back(mk(0, 1, 0, 0,             1, 0, 32'h0,         0, NOP, 32'hFFFF_FFFC));
        vq.push_back(mk(0, 1, 0, 0,             1, 1, 32'h4,         1, 32'hC000_0000, 32'h0));
        // Redirect flushes a full output+skid while decode consumes
        vq.push_back(mk(1, 0, 0, 0,        1, 1, 32'h100,  0, NOP, 32'h0));
        vq.push_back(mk(0, 0, 0, 0,        1, 0, 32'h0,    0, NOP, 32'h0));
        vq.push_back(mk(0, 0, 0, 0,        1, 1, 32'h104,  1, 32'hC000_0100, 32'h100));
        vq.push_back(mk(0, 0, 0, 0,        1, 0, 32'h0,    1, 32'hC000_0100, 32'h100));
        vq.push_back(mk(0, 1, 1, 32'h5000, 1, 0, 32'h0,    1, 32'hC000_0100, 32'h100));
        vq.push_back(mk(0, 1, 0, 0,        1, 1, 32'h5000, 0, NOP, 32'h100));
        vq.push_back(mk(0, 1, 0, 0,        1, 0, 32'h0,    0, NOP, 32'h100));
        vq.push_back(mk(0, 1, 0, 0,        1, 1, 32'h5004, 1, 32'hC000_5000, 32'h5000));

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], i);
        end

        // Reset pulse while a fetch is in flight and the output register is full
        do_reset(2);
        apply(mk(0, 0, 0, 0, 1, 1, 32'h100, 0, NOP, 32'h0), 100);
        apply(mk(0, 0, 0, 0, 1, 0, 32'h0,   0, NOP, 32'h0), 101);
        apply(mk(0, 0, 0, 0, 3, 1, 32'h104, 1, 32'hC000_0100, 32'h100), 102);
        do_reset(1);
        #1;
        $display("post-reset: req=%0b addr=%h id_valid=%0b instr=%h pc=%h",
                 imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc);
        chk("rst_mid id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_mid id_instr", id_instr, NOP);
        chk("rst_mid id_pc", id_pc, 32'h0);
        chk("rst_mid req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("rst_mid req_addr", imem_req_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_mid perf_fetched", perf_fetched, 32'h0);
`endif
        apply(mk(0, 1, 0, 0, 1, 1, 32'h100, 0, NOP, 32'h0), 103);
        apply(mk(0, 1, 0, 0, 1, 0, 32'h0,   0, NOP, 32'h0), 104);
        apply(mk(0, 1, 0, 0, 1, 1, 32'h104, 1, 32'hC000_0100, 32'h100), 105);
        apply(mk(0, 1, 0, 0, 1, 0, 32'h0,   0, NOP, 32'h100), 106);
`ifdef FETCH_PERF_CNT_EN
        #1;
        chk("perf_after_one_handshake", perf_fetched, 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
